// File: rtl/img_line_window.sv
// Streaming KxK window generator: K-1 line buffers feed K horizontal shift
// registers; one window per interior pixel, 2 cycles after the accepting edge.
module img_line_window #(
  parameter int DATA_W  = 16,
  parameter int K       = 3,
  parameter int IMG_COL = 512,
  parameter int IMG_ROW = 8,
  parameter int COL_W   = $clog2(IMG_COL),
  parameter int ROW_W   = $clog2(IMG_ROW)
) (
  input  logic                    cmos_pclk,
  input  logic                    rst,
  input  logic                    sof,
  input  logic [DATA_W-1:0]       pix_in,
  input  logic                    pix_in_en,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic                    win_valid,
  output logic [ROW_W-1:0]        win_row,
  output logic [COL_W-1:0]        win_col,
  output logic                    frame_done,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(K - 2);
  localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);

  state_t state, state_nxt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic accept, end_row, end_frame;

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = pix_in_en && !sof && (state == FILL || state == RUN);
    end_row   = (col_cnt == COL_LAST);
    end_frame = end_row && (row_cnt == ROW_LAST);
    case (state)
      IDLE:    state_nxt = IDLE;
      FILL:    if (accept && end_row && row_cnt == ROW_FILL_LAST) state_nxt = RUN;
      RUN:     if (accept && end_frame) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (sof) state_nxt = FILL;
  end

  assign busy = (state == FILL) || (state == RUN);

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (sof) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (end_row) begin
        col_cnt <= '0;
        row_cnt <= end_frame ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // stage 1: accepted pixel, its coordinates and window/last flags
  logic              v1, win1, last1;
  logic [DATA_W-1:0] pix1;
  logic [COL_W-1:0]  col1;
  logic [ROW_W-1:0]  row1;

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      win1  <= 1'b0;
      last1 <= 1'b0;
      pix1  <= '0;
      col1  <= '0;
      row1  <= '0;
    end else begin
      v1    <= accept;
      win1  <= accept && row_cnt >= ROW_FIRST_WIN && col_cnt >= COL_FIRST_WIN;
      last1 <= accept && end_frame;
      if (accept) begin
        pix1 <= pix_in;
        col1 <= col_cnt;
        row1 <= row_cnt;
      end
    end
  end

  logic [DATA_W-1:0] rd_bus  [K-1];
  logic [DATA_W-1:0] col_new [K];

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_COL];
    logic [DATA_W-1:0] rd_q, wr_d;
    if (j == 0) begin : g_first
      assign wr_d = pix1;
    end else begin : g_next
      assign wr_d = rd_bus[j-1];
    end
    // written one cycle after the read of the same column, so each row
    // ripples one buffer deeper per pass
    always_ff @(posedge cmos_pclk) begin
      if (v1) mem[col1] <= wr_d;
    end
    always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst)         rd_q <= '0;
      else if (accept) rd_q <= mem[col_cnt];
    end
    assign rd_bus[j]        = rd_q;
    assign col_new[K-2-j]   = rd_q;
  end
  assign col_new[K-1] = pix1;

  logic [DATA_W-1:0] tap [K][K];

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          tap[r][c] <= '0;
    end else if (v1) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) tap[r][c] <= tap[r][c+1];
        tap[r][K-1] <= col_new[r];
      end
    end
  end

  logic             win2, last2;
  logic [COL_W-1:0] col2;
  logic [ROW_W-1:0] row2;

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      win2  <= 1'b0;
      last2 <= 1'b0;
      col2  <= '0;
      row2  <= '0;
    end else begin
      win2  <= win1;
      last2 <= last1;
      col2  <= col1;
      row2  <= row1;
    end
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_data   <= '0;
    end else begin
      win_valid  <= win2;
      frame_done <= last2;
      if (win2) begin
        win_row <= row2;
        win_col <= col2;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win_data[(r*K+c)*DATA_W +: DATA_W] <= tap[r][c];
      end
    end
  end

endmodule
